// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
// Pipeline-wide constants and types shared by the write-back stage and the
// architectural register file.
//   WB_REGWRITE_BIT / WB_MEMTOREG_BIT : bit positions inside the 2-bit WB
//                                       control field carried by MEM/WB
//   DATA_W, REG_ID_W, NUM_REGS        : datapath / register-ID geometry
//   ZERO_REG                          : hard-wired zero register ID (r0)
//   wb_ctrl_t                         : packed view of the WB control field
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;
  localparam int DATA_W          = 32;
  localparam int REG_ID_W        = 5;
  localparam int NUM_REGS        = 32;

  localparam logic [REG_ID_W-1:0] ZERO_REG = 5'd0;

  // Field order matches the bit positions above: reg_write is bit 1.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_regfile_32x32.sv
// ---------------------------------------------------------------------------
// regfile_32x32
// Plain storage array: asynchronous clear, one synchronous write port and two
// asynchronous read ports. No r0 rule and no bypass here, so the array can be
// replaced by a latch- or SRAM-based macro without touching the pipeline.
// Ports:
//   clk, reset_n      : clock (rising edge), asynchronous active-low clear
//   we, waddr, wdata  : write port, committed on the rising edge
//   raddr1/2, rdata1/2: combinational read ports
// ---------------------------------------------------------------------------
module regfile_32x32
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = wb_regfile_pkg::DATA_W,
  parameter int NUM_REGS = wb_regfile_pkg::NUM_REGS
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [$clog2(NUM_REGS)-1:0] raddr1,
  input  logic [$clog2(NUM_REGS)-1:0] raddr2,
  output logic [DATA_W-1:0]           rdata1,
  output logic [DATA_W-1:0]           rdata2
);

  logic [DATA_W-1:0] regs_r [NUM_REGS];

  // Storage: clear every entry on reset, otherwise commit one write per edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Asynchronous read ports straight from the array.
  always_comb begin
    rdata1 = regs_r[raddr1];
    rdata2 = regs_r[raddr2];
  end

endmodule : regfile_32x32

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Write-back stage plus architectural register file of the 5-stage MIPS pipe.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   WB_IN                        : {RegWrite, MemtoReg} from MEM/WB
//   Mem_RDataIN, ALU_resultIN    : write-back candidates from MEM/WB
//   Reg_WIDIN                    : destination register ID
//   Read_ID1/2, Read_Data1/2     : ID-stage read ports with write-through bypass
//   WB_Data, WB_RegWrite         : write-back value / effective enable, to EX
//   Retire_Count                 : committed-write counter (wraps silently)
// ---------------------------------------------------------------------------
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = wb_regfile_pkg::DATA_W,
  parameter int NUM_REGS = wb_regfile_pkg::NUM_REGS
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [1:0]                  WB_IN,
  input  logic [DATA_W-1:0]           Mem_RDataIN,
  input  logic [DATA_W-1:0]           ALU_resultIN,
  input  logic [$clog2(NUM_REGS)-1:0] Reg_WIDIN,
  input  logic [$clog2(NUM_REGS)-1:0] Read_ID1,
  input  logic [$clog2(NUM_REGS)-1:0] Read_ID2,
  output logic [DATA_W-1:0]           Read_Data1,
  output logic [DATA_W-1:0]           Read_Data2,
  output logic [DATA_W-1:0]           WB_Data,
  output logic                        WB_RegWrite,
  output logic [31:0]                 Retire_Count
);

  localparam int ID_W = $clog2(NUM_REGS);
  localparam logic [ID_W-1:0] ZERO_ID = ID_W'(ZERO_REG);

  wb_ctrl_t          ctrl_s;
  logic [DATA_W-1:0] wb_data_s;
  logic              wr_en_s;
  logic [DATA_W-1:0] rf_rdata1_s;
  logic [DATA_W-1:0] rf_rdata2_s;
  logic [31:0]       retire_cnt_r;

  assign ctrl_s = wb_ctrl_t'(WB_IN);

  // Write-back select and effective enable. r0 writes are dropped, and the
  // enable is gated by reset so nothing is forwarded or bypassed while the
  // array is being cleared.
  always_comb begin
    if (ctrl_s.mem_to_reg) begin
      wb_data_s = Mem_RDataIN;
    end else begin
      wb_data_s = ALU_resultIN;
    end
    wr_en_s = reset_n & ctrl_s.reg_write & (Reg_WIDIN != ZERO_ID);
  end

  regfile_32x32 #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (wr_en_s),
    .waddr  (Reg_WIDIN),
    .wdata  (wb_data_s),
    .raddr1 (Read_ID1),
    .raddr2 (Read_ID2),
    .rdata1 (rf_rdata1_s),
    .rdata2 (rf_rdata2_s)
  );

  // Read ports: r0 reads zero, a same-cycle write to the addressed register
  // is bypassed, otherwise the stored value is returned.
  always_comb begin
    if (Read_ID1 == ZERO_ID) begin
      Read_Data1 = {DATA_W{1'b0}};
    end else if (wr_en_s && (Read_ID1 == Reg_WIDIN)) begin
      Read_Data1 = wb_data_s;
    end else begin
      Read_Data1 = rf_rdata1_s;
    end

    if (Read_ID2 == ZERO_ID) begin
      Read_Data2 = {DATA_W{1'b0}};
    end else if (wr_en_s && (Read_ID2 == Reg_WIDIN)) begin
      Read_Data2 = wb_data_s;
    end else begin
      Read_Data2 = rf_rdata2_s;
    end
  end

  // Retired-write counter, updated on the same edge as the commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_cnt_r <= 32'd0;
    end else if (wr_en_s) begin
      retire_cnt_r <= retire_cnt_r + 32'd1;
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign WB_Data      = wb_data_s;
  assign WB_RegWrite  = wr_en_s;
  assign Retire_Count = retire_cnt_r;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
// Directed bench for wb_regfile: inputs change 1 time unit after a rising
// edge, outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

  logic        clk;
  logic        reset_n;
  logic [1:0]  WB_IN;
  logic [31:0] Mem_RDataIN;
  logic [31:0] ALU_resultIN;
  logic [4:0]  Reg_WIDIN;
  logic [4:0]  Read_ID1;
  logic [4:0]  Read_ID2;
  logic [31:0] Read_Data1;
  logic [31:0] Read_Data2;
  logic [31:0] WB_Data;
  logic        WB_RegWrite;
  logic [31:0] Retire_Count;

  int checks;
  int failures;

  wb_regfile dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .WB_IN       (WB_IN),
    .Mem_RDataIN (Mem_RDataIN),
    .ALU_resultIN(ALU_resultIN),
    .Reg_WIDIN   (Reg_WIDIN),
    .Read_ID1    (Read_ID1),
    .Read_ID2    (Read_ID2),
    .Read_Data1  (Read_Data1),
    .Read_Data2  (Read_Data2),
    .WB_Data     (WB_Data),
    .WB_RegWrite (WB_RegWrite),
    .Retire_Count(Retire_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    failures     = 0;
    reset_n      = 1'b0;
    WB_IN        = 2'b00;
    Mem_RDataIN  = 32'h0000_0000;
    ALU_resultIN = 32'h0000_0000;
    Reg_WIDIN    = 5'd0;
    Read_ID1     = 5'd0;
    Read_ID2     = 5'd0;

    // Reset: write request must be suppressed while reset_n is low.
    tick();
    WB_IN = 2'b10; ALU_resultIN = 32'h1111_1111; Reg_WIDIN = 5'd3; Read_ID1 = 5'd3;
    #1;
    check("rst_wbregwrite", {31'd0, WB_RegWrite}, 32'd0);
    check("rst_no_bypass", Read_Data1, 32'h0000_0000);
    check("rst_wbdata_follows", WB_Data, 32'h1111_1111);
    tick();
    WB_IN = 2'b00;
    tick();
    reset_n = 1'b1;
    #1;
    check("rst_retire", Retire_Count, 32'd0);
    for (int i = 0; i < 32; i++) begin
      Read_ID1 = 5'(i);
      Read_ID2 = 5'(31 - i);
      #1;
      check($sformatf("rst_rd1_r%0d", i), Read_Data1, 32'd0);
      check($sformatf("rst_rd2_r%0d", 31 - i), Read_Data2, 32'd0);
    end

    // ALU write to r8.
    tick();
    WB_IN = 2'b10; ALU_resultIN = 32'h1234_5678; Mem_RDataIN = 32'h5555_5555; Reg_WIDIN = 5'd8;
    Read_ID1 = 5'd1; Read_ID2 = 5'd2;
    #1;
    check("alu_wbdata", WB_Data, 32'h1234_5678);
    check("alu_wbregwrite", {31'd0, WB_RegWrite}, 32'd1);
    tick();
    WB_IN = 2'b00; Read_ID1 = 5'd8;
    #1;
    check("alu_readback", Read_Data1, 32'h1234_5678);
    check("alu_retire", Retire_Count, 32'd1);

    // Load write to r9.
    WB_IN = 2'b11; Mem_RDataIN = 32'hDEAD_BEEF; ALU_resultIN = 32'h0000_0040; Reg_WIDIN = 5'd9;
    #1;
    check("load_wbdata", WB_Data, 32'hDEAD_BEEF);
    tick();
    WB_IN = 2'b00; Read_ID2 = 5'd9;
    #1;
    check("load_readback", Read_Data2, 32'hDEAD_BEEF);
    check("load_retire", Retire_Count, 32'd2);

    // Same-cycle bypass on both ports.
    WB_IN = 2'b10; ALU_resultIN = 32'hCAFE_0001; Reg_WIDIN = 5'd8;
    Read_ID1 = 5'd8; Read_ID2 = 5'd8;
    #1;
    check("byp_rd1", Read_Data1, 32'hCAFE_0001);
    check("byp_rd2", Read_Data2, 32'hCAFE_0001);
    Read_ID2 = 5'd9;
    #1;
    check("byp_other_port", Read_Data2, 32'hDEAD_BEEF);
    tick();
    WB_IN = 2'b00;
    #1;
    check("byp_committed", Read_Data1, 32'hCAFE_0001);
    check("byp_retire", Retire_Count, 32'd3);

    // Write to r0 is dropped.
    WB_IN = 2'b10; ALU_resultIN = 32'hFFFF_FFFF; Reg_WIDIN = 5'd0; Read_ID1 = 5'd0;
    #1;
    check("r0_wbregwrite", {31'd0, WB_RegWrite}, 32'd0);
    check("r0_read_same", Read_Data1, 32'd0);
    tick();
    WB_IN = 2'b00;
    #1;
    check("r0_read_after", Read_Data1, 32'd0);
    check("r0_retire", Retire_Count, 32'd3);

    // Disabled write to r5 leaves the stored value alone.
    WB_IN = 2'b10; ALU_resultIN = 32'h0000_0555; Reg_WIDIN = 5'd5;
    tick();
    WB_IN = 2'b01; ALU_resultIN = 32'h0000_0BAD; Mem_RDataIN = 32'h0000_0DAD; Read_ID1 = 5'd5;
    #1;
    check("dis_wbdata_mem", WB_Data, 32'h0000_0DAD);
    check("dis_wbregwrite", {31'd0, WB_RegWrite}, 32'd0);
    check("dis_no_bypass", Read_Data1, 32'h0000_0555);
    WB_IN = 2'b00;
    tick();
    check("dis_unchanged", Read_Data1, 32'h0000_0555);
    check("dis_retire", Retire_Count, 32'd4);

    // Counter wrap through a backdoor preload.
    force dut.retire_cnt_r = 32'hFFFF_FFFF;
    #1;
    check("wrap_preload", Retire_Count, 32'hFFFF_FFFF);
    release dut.retire_cnt_r;
    WB_IN = 2'b10; ALU_resultIN = 32'h0000_0077; Reg_WIDIN = 5'd10;
    tick();
    WB_IN = 2'b00; Read_ID1 = 5'd10;
    #1;
    check("wrap_retire", Retire_Count, 32'd0);
    check("wrap_write", Read_Data1, 32'h0000_0077);

    // Reset asserted mid-cycle during an active write.
    WB_IN = 2'b10; ALU_resultIN = 32'h0000_0099; Reg_WIDIN = 5'd8;
    Read_ID1 = 5'd8; Read_ID2 = 5'd9;
    #1;
    check("mid_pre_bypass", Read_Data1, 32'h0000_0099);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_wbregwrite", {31'd0, WB_RegWrite}, 32'd0);
    check("mid_rd1_cleared", Read_Data1, 32'd0);
    check("mid_rd2_cleared", Read_Data2, 32'd0);
    check("mid_retire", Retire_Count, 32'd0);
    tick();
    check("mid_no_write", Read_Data1, 32'd0);
    WB_IN = 2'b00;
    tick();
    reset_n = 1'b1;
    Read_ID1 = 5'd10;
    #1;
    check("mid_r10_cleared", Read_Data1, 32'd0);

    // First write after release lands on the next edge.
    WB_IN = 2'b11; Mem_RDataIN = 32'hA5A5_0012; Reg_WIDIN = 5'd12;
    tick();
    WB_IN = 2'b00; Read_ID2 = 5'd12;
    #1;
    check("post_rst_write", Read_Data2, 32'hA5A5_0012);
    check("post_rst_retire", Retire_Count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wb_regfile
